// File: rtl/mlu_wide_seq_if.sv
// Bundled request, response and mlu-side signals for the multi-word mlu sequencer.
// The slave modport is the sequencer's view; the master modport is its environment's view.
interface mlu_wide_seq_if #(
  parameter int WORDS = 2
);
  localparam int W = WORDS * 32;

  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_c_in;

  logic [31:0]  mlu_a;
  logic [31:0]  mlu_b;
  logic [2:0]   mlu_op;
  logic         mlu_c_in;
  logic [31:0]  mlu_out;
  logic         mlu_z;
  logic         mlu_c;
  logic         mlu_n;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_out;
  logic         rsp_z;
  logic         rsp_c;
  logic         rsp_n;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c_in,
    output req_ready,
    output mlu_a, mlu_b, mlu_op, mlu_c_in,
    input  mlu_out, mlu_z, mlu_c, mlu_n,
    output rsp_valid, rsp_out, rsp_z, rsp_c, rsp_n,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_c_in,
    input  req_ready,
    input  mlu_a, mlu_b, mlu_op, mlu_c_in,
    output mlu_out, mlu_z, mlu_c, mlu_n,
    input  rsp_valid, rsp_out, rsp_z, rsp_c, rsp_n,
    output rsp_ready
  );
endinterface

// File: rtl/mlu_wide_seq.sv
// Multi-word initiator for the 32-bit mlu: issues a WORDS*32-bit operation one word
// per cycle (LSW first), chaining carry and accumulating Z, then returns the result.
package common;
  typedef enum logic [2:0] {
    MLU_NOP0 = 3'd0,
    MLU_ADD  = 3'd1,
    MLU_SUB  = 3'd2,
    MLU_NOT  = 3'd3,
    MLU_AND  = 3'd4,
    MLU_OR   = 3'd5,
    MLU_XOR  = 3'd6,
    MLU_NOP1 = 3'd7
  } mlu_op_e;
endpackage

module mlu_wide_seq #(
  parameter int WORDS = 2
) (
  input  logic         clk,
  input  logic         rst,
  mlu_wide_seq_if.slave bus
);
  import common::*;

  localparam int W     = WORDS * 32;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q,  state_d;
  logic [IDX_W-1:0]    idx_q,    idx_d;
  mlu_op_e             op_q,     op_d;
  logic [W-1:0]        a_q,      a_d;
  logic [W-1:0]        b_q,      b_d;
  logic [W-1:0]        result_q, result_d;
  logic                carry_q,  carry_d;
  logic                zacc_q,   zacc_d;
  logic                n_q,      n_d;

  logic last_word;
  logic is_arith;

  assign last_word = (idx_q == IDX_W'(WORDS - 1));
  assign is_arith  = (op_q == MLU_ADD) || (op_q == MLU_SUB);

  always_comb begin
    // NOTE: every combinational output gets a default before the case; any path
    // that skipped an assignment would otherwise infer a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    result_d      = result_q;
    carry_d       = carry_q;
    zacc_d        = zacc_q;
    n_d           = n_q;
    bus.req_ready = (state_q == S_IDLE) && !rst;
    bus.rsp_valid = 1'b0;
    bus.mlu_a     = '0;
    bus.mlu_b     = '0;
    bus.mlu_op    = MLU_NOP0;
    bus.mlu_c_in  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          op_d    = mlu_op_e'(bus.req_op);
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          idx_d   = '0;
          zacc_d  = 1'b1;
          // Subtract is A + ~B + 1 in the mlu, so the first word always gets carry 1.
          carry_d = (mlu_op_e'(bus.req_op) == MLU_ADD) ? bus.req_c_in :
                    (mlu_op_e'(bus.req_op) == MLU_SUB);
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        bus.mlu_a    = a_q[int'(idx_q)*32 +: 32];
        bus.mlu_b    = b_q[int'(idx_q)*32 +: 32];
        bus.mlu_op   = op_q;
        bus.mlu_c_in = carry_q;
        result_d[int'(idx_q)*32 +: 32] = bus.mlu_out;
        zacc_d  = zacc_q & bus.mlu_z;
        carry_d = is_arith & bus.mlu_c;
        idx_d   = idx_q + 1'b1;
        if (last_word) begin
          n_d     = bus.mlu_n;
          idx_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rsp_out = result_q;
  assign bus.rsp_z   = zacc_q;
  assign bus.rsp_c   = carry_q;
  assign bus.rsp_n   = n_q;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the datapath registers are reset too, because an aborted
  // operation must leave no partial result behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      op_q     <= MLU_NOP0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      n_q      <= n_d;
    end
  end
endmodule

// File: tb/tb_mlu_wide_seq.sv
// Directed bench for mlu_wide_seq with WORDS=2 and a behavioural 32-bit mlu
// attached to the mlu-side ports.
module tb_mlu_wide_seq;
  localparam int WORDS = 2;

  localparam logic [2:0] OP_NOP0 = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  mlu_wide_seq_if #(.WORDS(WORDS)) bus ();

  mlu_wide_seq #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 32-bit mlu: SUB is A + ~B + C_IN, C is the bit-32 carry.
  logic [32:0] mlu_sum;
  logic [31:0] mlu_res;
  logic        mlu_cy;
  always_comb begin
    mlu_sum = '0;
    mlu_res = '0;
    mlu_cy  = 1'b0;
    case (bus.mlu_op)
      OP_ADD: begin
        mlu_sum = {1'b0, bus.mlu_a} + {1'b0, bus.mlu_b} + 33'(bus.mlu_c_in);
        mlu_res = mlu_sum[31:0];
        mlu_cy  = mlu_sum[32];
      end
      OP_SUB: begin
        mlu_sum = {1'b0, bus.mlu_a} + {1'b0, ~bus.mlu_b} + 33'(bus.mlu_c_in);
        mlu_res = mlu_sum[31:0];
        mlu_cy  = mlu_sum[32];
      end
      OP_NOT:  mlu_res = ~bus.mlu_a;
      OP_AND:  mlu_res = bus.mlu_a & bus.mlu_b;
      OP_OR:   mlu_res = bus.mlu_a | bus.mlu_b;
      OP_XOR:  mlu_res = bus.mlu_a ^ bus.mlu_b;
      default: mlu_res = '0;
    endcase
  end
  assign bus.mlu_out = mlu_res;
  assign bus.mlu_c   = mlu_cy;
  assign bus.mlu_z   = (mlu_res == 32'h0);
  assign bus.mlu_n   = mlu_res[31];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE (called at a negedge) and complete its response.
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, output logic [63:0] out, output logic z,
                        output logic c, output logic n, output int lat, output logic cin0);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_c_in  = cin;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    cin0 = bus.mlu_c_in;
    lat  = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    out = bus.rsp_out;
    z   = bus.rsp_z;
    c   = bus.rsp_c;
    n   = bus.rsp_n;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] out, held;
    logic        z, c, n, cin0;
    int          lat;

    n_vec = 0;
    n_bad = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NOP0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c_in  = 1'b0;
    bus.rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_mlu_op",    64'(bus.mlu_op),    64'd0);
    check("rst_rsp_out",   bus.rsp_out,        64'd0);
    check("rst_flags",     64'({bus.rsp_z, bus.rsp_c, bus.rsp_n}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 64'(bus.req_ready), 64'd1);

    // Carry ripples from the low word into the high word.
    run_op(OP_ADD, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, out, z, c, n, lat, cin0);
    check("add_carry_out", out, 64'h00000001_00000000);
    check("add_carry_zcn", 64'({z, c, n}), 64'b000);
    check("add_latency",   64'(lat), 64'd2);
    check("add_after_ack", 64'(bus.rsp_valid), 64'd0);

    // Borrow through both words; carry-in forced to 1 despite REQ_C_IN=0.
    run_op(OP_SUB, 64'h0, 64'h1, 1'b0, out, z, c, n, lat, cin0);
    check("sub_borrow_out", out, 64'hFFFFFFFF_FFFFFFFF);
    check("sub_borrow_zcn", 64'({z, c, n}), 64'b001);
    check("sub_first_cin",  64'(cin0), 64'd1);

    run_op(OP_SUB, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0, out, z, c, n, lat, cin0);
    check("sub_equal_out", out, 64'h0);
    check("sub_equal_zcn", 64'({z, c, n}), 64'b110);

    run_op(OP_ADD, 64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b0, out, z, c, n, lat, cin0);
    check("add_wrap_out", out, 64'h0);
    check("add_wrap_zc",  64'({z, c}), 64'b11);

    run_op(OP_ADD, 64'h00000005_00000001, 64'h00000003_00000002, 1'b1, out, z, c, n, lat, cin0);
    check("add_cin_out", out, 64'h00000008_00000004);

    // Backpressure: response held for 5 cycles while a new request is pending.
    bus.req_op    = OP_ADD;
    bus.req_a     = 64'h00000002_00000003;
    bus.req_b     = 64'h00000001_00000004;
    bus.req_c_in  = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_a = 64'h1;
    bus.req_b = 64'h1;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 64'(lat), 64'd2);
    held = bus.rsp_out;
    check("bp_result", held, 64'h00000003_00000007);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
      check("bp_rsp_out",   bus.rsp_out, 64'h00000003_00000007);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("bp_idle_valid", 64'(bus.rsp_valid), 64'd0);
    check("bp_idle_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("b2b_exec_op", 64'(bus.mlu_op), 64'(OP_ADD));
    check("b2b_exec_a",  64'(bus.mlu_a),  64'd1);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_out", bus.rsp_out, 64'h2);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // Logic ops and NOP.
    run_op(OP_XOR, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D, 1'b1, out, z, c, n, lat, cin0);
    check("xor_out", out, 64'h0);
    check("xor_zc",  64'({z, c}), 64'b10);
    check("xor_latency", 64'(lat), 64'd2);

    run_op(OP_NOT, 64'h0, 64'h0, 1'b0, out, z, c, n, lat, cin0);
    check("not_out", out, 64'hFFFFFFFF_FFFFFFFF);
    check("not_zcn", 64'({z, c, n}), 64'b001);

    run_op(OP_AND, 64'hF0F0F0F0_0000FFFF, 64'hFF00FF00_FFFF0000, 1'b0, out, z, c, n, lat, cin0);
    check("and_out", out, 64'hF000F000_00000000);
    check("and_zcn", 64'({z, c, n}), 64'b001);

    run_op(OP_OR, 64'h00000000_00000001, 64'h00000000_00010000, 1'b0, out, z, c, n, lat, cin0);
    check("or_out", out, 64'h00000000_00010001);
    check("or_zcn", 64'({z, c, n}), 64'b000);

    run_op(OP_NOP0, 64'h12345678_12345678, 64'h1, 1'b1, out, z, c, n, lat, cin0);
    check("nop_out", out, 64'h0);
    check("nop_zc",  64'({z, c}), 64'b10);

    // Reset after the first word of an ADD aborts it.
    bus.req_op    = OP_ADD;
    bus.req_a     = 64'h00000007_00000005;
    bus.req_b     = 64'h00000001_00000001;
    bus.req_c_in  = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("abort_req_ready", 64'(bus.req_ready), 64'd0);
    check("abort_mlu_op",    64'(bus.mlu_op),    64'd0);
    check("abort_rsp_out",   bus.rsp_out,        64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.req_ready), 64'd1);
    check("post_rst_valid", 64'(bus.rsp_valid), 64'd0);

    run_op(OP_ADD, 64'h1, 64'h1, 1'b0, out, z, c, n, lat, cin0);
    check("post_rst_add", out, 64'h2);
    check("post_rst_latency", 64'(lat), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
